logic_equiv_sweeper: RTL
========================

Name: logic_equiv_sweeper

Overview:
Sequential truth-table sweeper and equivalence checker for combinational gate models. Drives every N_IN-bit input combination, in binary or Gray order, onto a shared stimulus bus feeding two external implementations of the same function, such as a gate-level model and an expression model. Samples both responses after a settle delay, counts mismatching minterms and records the first failure. It is the bench-side engine that replaces hand-written truth-table initial blocks in the guide exercises.

Parameters:
N_IN, 2, number of function inputs; sweep length 2^N_IN vectors; range 1..16
N_OUT, 1, width of each response bus
SETTLE, 1, cycles each vector is held before sampling; must be >=1

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous and active-low
start  input  1  begin a sweep; sampled only in IDLE
gray  input  1  0 = ascending binary order, 1 = Gray order; latched at start
stim  output  N_IN  stimulus vector to both implementations
resp_a  input  N_OUT  response of implementation A
resp_b  input  N_OUT  response of implementation B
busy  output  1  high while a sweep runs
done  output  1  one-cycle pulse when a sweep completes
pass  output  1  1 when last sweep had zero mismatches
err_cnt  output  N_IN+1  number of mismatching vectors in last sweep
first_err_m  output  N_IN  stimulus value of first mismatch
first_err_vld  output  1  first_err_m holds a valid value

Behaviour:
- Reset (async, rst_n=0): state=IDLE; stim=0, busy=0, done=0, pass=0, err_cnt=0, first_err_m=0, first_err_vld=0; index and settle counters=0. Applies immediately, including mid-sweep; no partial results survive.
- Internal index idx, N_IN+1 bits wide. stim = idx[N_IN-1:0] in binary mode, and idx ^ (idx>>1) truncated to N_IN bits in Gray mode.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with start=1:
  - latch gray;
  - clear err_cnt, pass, first_err_vld and first_err_m;
  - set idx=0 and settle_cnt=SETTLE;
  - set busy=1 and go to RUN.
- RUN:
  - Each edge decrements settle_cnt.
  - On the edge where settle_cnt==1 (the vector has been held SETTLE cycles), compare resp_a against resp_b across all N_OUT bits.
  - On mismatch, err_cnt+=1. If first_err_vld==0, also set first_err_m=stim and first_err_vld=1.
  - On that same edge, if idx==2^N_IN-1, go to DONE. Otherwise set idx+=1 and reload settle_cnt=SETTLE; the new stim appears after that edge.
- Sweep timing: start edge to DONE entry is exactly 2^N_IN*SETTLE cycles.
- DONE (one cycle): done=1, busy=0, pass=(err_cnt==0). stim holds the last vector. Next edge returns to IDLE with done=0.
- Results (pass, err_cnt, first_err_*) hold until the next accepted start or reset.
- start is ignored in RUN and DONE, with no queuing. start held high continuously re-arms on the first IDLE cycle after DONE.
- Changes to gray mid-sweep are ignored.
- err_cnt cannot overflow: max 2^N_IN fits in N_IN+1 bits.
- X/Z on resp inputs counts as a mismatch: use case-inequality (!==), not !=.

Optional Feature:
SWEEP_ABORT_EN. When defined, the first mismatch ends the sweep immediately. On that compare edge, go to DONE with err_cnt=1, first_err_m/first_err_vld set and pass=0; remaining vectors are not driven. When undefined, the sweep always covers all 2^N_IN vectors and err_cnt is the total count.

Test Plan:
- N_IN=2, SETTLE=1, binary mode; A=gate-level NAND, B=~(a&b) -> stim 00,01,10,11 on consecutive cycles; done pulse 4 cycles after start; pass=1, err_cnt=0, first_err_vld=0.
- Same, but B=a&b (faulty) -> err_cnt=4, first_err_m=00, pass=0. With SWEEP_ABORT_EN: done 1 cycle after start, err_cnt=1.
- N_IN=2, gray=1, B differs only at a=1,b=0 -> stim order 00,01,11,10; err_cnt=1, first_err_m=10, detected on the 4th compare.
- N_IN=3, SETTLE=3 -> each stim value is stable exactly 3 cycles; done pulses 24 cycles after the start edge; busy is high for 24 cycles.
- Assert rst_n=0 mid-sweep (idx=2), then release and start again -> outputs go to reset values immediately, without waiting for a clock edge; the new sweep starts at stim=0 with a fresh err_cnt.
- Pulse start during RUN and during DONE -> ignored, with no extra sweep. Hold start=1 -> back-to-back sweeps with one IDLE cycle between done and the next stim=0.

Source files
------------

// File: rtl/logic_equiv_sweeper_if.sv
// Stimulus/response and result bus between the truth-table sweeper and its bench.
// master = bench side (start, mode, responses); slave = sweeper side.
interface logic_equiv_sweeper_if #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 1
);
  logic             start;
  logic             gray;
  logic [N_IN-1:0]  stim;
  logic [N_OUT-1:0] resp_a;
  logic [N_OUT-1:0] resp_b;
  logic             busy;
  logic             done;
  logic             pass;
  logic [N_IN:0]    err_cnt;
  logic [N_IN-1:0]  first_err_m;
  logic             first_err_vld;

  modport master (
    output start, gray, resp_a, resp_b,
    input  stim, busy, done, pass, err_cnt, first_err_m, first_err_vld
  );

  modport slave (
    input  start, gray, resp_a, resp_b,
    output stim, busy, done, pass, err_cnt, first_err_m, first_err_vld
  );
endinterface

// File: rtl/logic_equiv_sweeper.sv
// Truth-table sweeper: drives every N_IN-bit vector (binary or Gray order) and counts
// vectors where two implementations disagree. Define SWEEP_ABORT_EN to stop on the first mismatch.
module logic_equiv_sweeper #(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  logic_equiv_sweeper_if.slave  bus
);
  // state | meaning
  // IDLE  | waiting for start; results of the last sweep held
  // RUN   | holding a vector for SETTLE cycles, then comparing
  // DONE  | one-cycle done pulse, pass updated
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [N_IN:0] LAST = {1'b0, {N_IN{1'b1}}};

  state_t          state;
  logic            gray_q;
  logic [N_IN:0]   idx;
  logic [SW-1:0]   settle_cnt;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_cnt;
  logic [N_IN-1:0] first_err_m;
  logic            first_err_vld;

  logic [N_IN-1:0] stim_bin;
  logic [N_IN-1:0] stim_gray;
  logic [N_IN-1:0] stim;
  logic            mismatch;
  logic            last_vec;
  logic            sweep_end;
  logic [N_IN:0]   err_next;

  assign stim_bin  = idx[N_IN-1:0];
  // idx ^ (idx >> 1), keeping only the low N_IN bits
  assign stim_gray = idx[N_IN-1:0] ^ idx[N_IN:1];
  assign stim      = gray_q ? stim_gray : stim_bin;

  // Case inequality so X/Z on either response is reported as a mismatch
  assign mismatch  = (bus.resp_a !== bus.resp_b);
  assign last_vec  = (idx == LAST);
  assign err_next  = err_cnt + (N_IN + 1)'(mismatch);

`ifdef SWEEP_ABORT_EN
  assign sweep_end = last_vec | mismatch;
`else
  assign sweep_end = last_vec;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      gray_q        <= 1'b0;
      idx           <= '0;
      settle_cnt    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      first_err_m   <= '0;
      first_err_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            gray_q        <= bus.gray;
            err_cnt       <= '0;
            pass          <= 1'b0;
            first_err_vld <= 1'b0;
            first_err_m   <= '0;
            idx           <= '0;
            settle_cnt    <= SW'(SETTLE);
            busy          <= 1'b1;
            state         <= RUN;
          end
        end
        RUN: begin
          settle_cnt <= settle_cnt - 1'b1;
          if (settle_cnt == SW'(1)) begin
            if (mismatch) begin
              err_cnt <= err_next;
              if (!first_err_vld) begin
                first_err_m   <= stim;
                first_err_vld <= 1'b1;
              end
            end
            if (sweep_end) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
              state <= DONE;
            end else begin
              idx        <= idx + 1'b1;
              settle_cnt <= SW'(SETTLE);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stim          = stim;
  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.pass          = pass;
  assign bus.err_cnt       = err_cnt;
  assign bus.first_err_m   = first_err_m;
  assign bus.first_err_vld = first_err_vld;
endmodule
